// File: rtl/bottomhalf_bus_initiator_pkg.sv
// Shared constants for the bottom-half parallel bus initiator: address map details,
// FSM state encodings and a helper for phase timer load values.
package bottomhalf_bus_initiator_pkg;

   // Bus address bit the caller sets to mark a valid slave access
   localparam int unsigned ADDR_OK_BIT = 4;

   // Read-only identification registers present in every bottom-half bitfile
   localparam logic [7:0] ID_TYPE_LO_ADDR = 8'hFD;
   localparam logic [7:0] ID_TYPE_HI_ADDR = 8'hFE;
   localparam logic [7:0] ID_SUBTYPE_ADDR = 8'hFF;

   // Initiator FSM state encodings
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ADDR_SETUP = 3'd1;
   localparam logic [2:0] ST_ADDR_PULSE = 3'd2;
   localparam logic [2:0] ST_ADDR_HOLD  = 3'd3;
   localparam logic [2:0] ST_DATA_SETUP = 3'd4;
   localparam logic [2:0] ST_STROBE     = 3'd5;
   localparam logic [2:0] ST_RECOVER    = 3'd6;

   // A phase lasting 'cycles' osc cycles loads its down-counter with cycles-1
   function automatic logic [7:0] phase_load(input int unsigned cycles);
      return 8'(cycles - 1);
   endfunction

endpackage

// File: rtl/bottomhalf_bus_initiator_phase_timer.sv
// Loadable 8-bit down-counter that times each bus phase; done is high at count zero.
module bottomhalf_bus_initiator_phase_timer (
   input  logic       osc,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       done
);

   logic [7:0] count;

   // Load on phase entry, otherwise count down and park at zero
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign done = (count == 8'd0);

endmodule

// File: rtl/bottomhalf_bus_initiator.sv
// Bottom-half bus initiator: turns single-word read/write requests into timed
// ALE / WRITE / READ cycles, skipping the address phase when the slave already
// holds the requested address.
module bottomhalf_bus_initiator
   import bottomhalf_bus_initiator_pkg::*;
#(
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_PULSE    = 3,
   parameter int unsigned T_RECOVER  = 2,
   parameter int unsigned ADDR_CACHE = 1
) (
   input  logic       osc,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   input  logic [7:0] bus_data_in,
   output logic       bus_ale,
   output logic       bus_write,
   output logic       bus_read
);

   localparam logic [7:0] LD_SETUP   = phase_load(T_SETUP);
   localparam logic [7:0] LD_PULSE   = phase_load(T_PULSE);
   localparam logic [7:0] LD_RECOVER = phase_load(T_RECOVER);

   logic [2:0] state_q, state_d;
   logic       lat_write_q;
   logic [7:0] lat_addr_q, lat_wdata_q;
   logic [7:0] cache_addr_q;
   logic       cache_valid_q;
   logic [7:0] rdata_q;
   logic       tmr_load, tmr_done;
   logic [7:0] tmr_val;
   logic       accept, cache_hit;

   // req_ready is forced low during reset even though the state is already IDLE
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign cache_hit = (ADDR_CACHE != 0) && cache_valid_q && (req_addr == cache_addr_q);

   bottomhalf_bus_initiator_phase_timer u_timer (
      .osc      (osc),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Phase sequencing: each timed state exits when its counter reaches zero
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = 8'd0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = cache_hit ? ST_DATA_SETUP : ST_ADDR_SETUP;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
            end
         end
         ST_ADDR_SETUP: begin
            if (tmr_done) begin
               state_d  = ST_ADDR_PULSE;
               tmr_load = 1'b1;
               tmr_val  = LD_PULSE;
            end
         end
         ST_ADDR_PULSE: begin
            if (tmr_done) begin
               state_d  = ST_ADDR_HOLD;
               tmr_load = 1'b1;
               tmr_val  = LD_RECOVER;
            end
         end
         ST_ADDR_HOLD: begin
            if (tmr_done) begin
               state_d  = ST_DATA_SETUP;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
            end
         end
         ST_DATA_SETUP: begin
            if (tmr_done) begin
               state_d  = ST_STROBE;
               tmr_load = 1'b1;
               tmr_val  = LD_PULSE;
            end
         end
         ST_STROBE: begin
            if (tmr_done) begin
               state_d  = ST_RECOVER;
               tmr_load = 1'b1;
               tmr_val  = LD_RECOVER;
            end
         end
         ST_RECOVER: begin
            if (tmr_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request at accept so later changes on the request port are ignored
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         lat_write_q <= 1'b0;
         lat_addr_q  <= 8'd0;
         lat_wdata_q <= 8'd0;
      end else if (accept) begin
         lat_write_q <= req_write;
         lat_addr_q  <= req_addr;
         lat_wdata_q <= req_wdata;
      end
   end

   // Remember the slave's latched address once its ALE falling edge has completed
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         cache_addr_q  <= 8'd0;
         cache_valid_q <= 1'b0;
      end else if ((state_q == ST_ADDR_HOLD) && tmr_done) begin
         cache_addr_q  <= lat_addr_q;
         cache_valid_q <= 1'b1;
      end
   end

   // Sample read data on the last READ-low cycle, while the slave still drives the bus
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         rdata_q <= 8'd0;
      end else if ((state_q == ST_STROBE) && tmr_done && !lat_write_q) begin
         rdata_q <= bus_data_in;
      end
   end

   assign rsp_rdata = rdata_q;

   // Bus pin decode from the current phase
   always_comb begin
      bus_data_out = 8'd0;
      bus_data_oe  = 1'b0;
      bus_ale      = 1'b0;
      bus_write    = 1'b1;
      bus_read     = 1'b1;
      rsp_valid    = 1'b0;
      case (state_q)
         ST_ADDR_SETUP, ST_ADDR_HOLD: begin
            bus_data_oe  = 1'b1;
            bus_data_out = lat_addr_q;
         end
         ST_ADDR_PULSE: begin
            bus_data_oe  = 1'b1;
            bus_data_out = lat_addr_q;
            bus_ale      = 1'b1;
         end
         ST_DATA_SETUP: begin
            // Reads leave the bus undriven so it has turned around before READ falls
            if (lat_write_q) begin
               bus_data_oe  = 1'b1;
               bus_data_out = lat_wdata_q;
            end
         end
         ST_STROBE: begin
            if (lat_write_q) begin
               bus_data_oe  = 1'b1;
               bus_data_out = lat_wdata_q;
               bus_write    = 1'b0;
            end else begin
               bus_read = 1'b0;
            end
         end
         ST_RECOVER: begin
            // Write data is held after the WRITE rising edge for the slave's hold time
            if (lat_write_q) begin
               bus_data_oe  = 1'b1;
               bus_data_out = lat_wdata_q;
            end
            rsp_valid = tmr_done;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bottomhalf_bus_initiator.sv
// Self-checking bench for bottomhalf_bus_initiator: a bottom-half slave model on the
// bus, a table of directed transfers, hand sequences for reset/backpressure/no-cache,
// and randomized transfers checked against a transaction-level reference model.
module tb_bottomhalf_bus_initiator;
   import bottomhalf_bus_initiator_pkg::*;

   localparam int unsigned TS = 2, TP = 3, TR = 2;
   localparam int unsigned FULL_CYC = 2 * (TS + TP + TR);
   localparam int unsigned HIT_CYC  = TS + TP + TR;

   logic osc = 1'b0;
   logic rst = 1'b1;
   always #5 osc = ~osc;

   logic       req_valid = 1'b0, req_write = 1'b0;
   logic [7:0] req_addr = 8'd0, req_wdata = 8'd0;
   logic       req_ready, rsp_valid;
   logic [7:0] rsp_rdata, bus_data_out, bus_data_in;
   logic       bus_data_oe, bus_ale, bus_write, bus_read;

   logic       nc_req_valid = 1'b0;
   logic [7:0] nc_bus_data_in = 8'd0;
   logic       nc_req_ready, nc_rsp_valid, nc_bus_data_oe, nc_bus_ale, nc_bus_write, nc_bus_read;
   logic [7:0] nc_rsp_rdata, nc_bus_data_out;

   bottomhalf_bus_initiator #(
      .T_SETUP(TS), .T_PULSE(TP), .T_RECOVER(TR), .ADDR_CACHE(1)
   ) u_dut (
      .osc(osc), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_data_out(bus_data_out),
      .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in), .bus_ale(bus_ale),
      .bus_write(bus_write), .bus_read(bus_read)
   );

   bottomhalf_bus_initiator #(
      .T_SETUP(TS), .T_PULSE(TP), .T_RECOVER(TR), .ADDR_CACHE(0)
   ) u_dut_nc (
      .osc(osc), .rst(rst), .req_valid(nc_req_valid), .req_ready(nc_req_ready),
      .req_write(1'b1), .req_addr(8'h10), .req_wdata(8'h66),
      .rsp_valid(nc_rsp_valid), .rsp_rdata(nc_rsp_rdata), .bus_data_out(nc_bus_data_out),
      .bus_data_oe(nc_bus_data_oe), .bus_data_in(nc_bus_data_in), .bus_ale(nc_bus_ale),
      .bus_write(nc_bus_write), .bus_read(nc_bus_read)
   );

   // ---------------- bottom-half slave model ----------------
   logic [7:0] slv_mem [256];
   logic [7:0] slv_addr = 8'd0;

   initial begin
      for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;
      slv_mem[ID_TYPE_LO_ADDR] = 8'h34;
      slv_mem[ID_TYPE_HI_ADDR] = 8'h12;
      slv_mem[ID_SUBTYPE_ADDR] = 8'h01;
   end

   always @(negedge bus_ale) slv_addr = bus_data_out;
   always @(posedge bus_write) if (!rst && slv_addr < ID_TYPE_LO_ADDR) slv_mem[slv_addr] = bus_data_out;
   assign bus_data_in = !bus_read ? slv_mem[slv_addr] : 8'h00;

   // ---------------- bus protocol checker ----------------
   int viol = 0;
   always @(negedge osc) begin
      if (!rst && (($countones({bus_ale, ~bus_write, ~bus_read}) > 1) || (bus_data_oe && !bus_read)))
         viol++;
   end

   // ---------------- checking helpers ----------------
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: transaction-level view of slave contents and initiator's address cache
   logic [7:0] ref_mem [256];
   logic       ref_cache_valid = 1'b0;
   logic [7:0] ref_cache_addr = 8'd0;

   function automatic int unsigned ref_cycles(input logic [7:0] a);
      return (ref_cache_valid && ref_cache_addr == a) ? HIT_CYC : FULL_CYC;
   endfunction

   function automatic int unsigned ref_ale(input logic [7:0] a);
      return (ref_cache_valid && ref_cache_addr == a) ? 0 : 1;
   endfunction

   task automatic ref_update(input logic w, input logic [7:0] a, input logic [7:0] d);
      if (w && a < ID_TYPE_LO_ADDR) ref_mem[a] = d;
      ref_cache_valid = 1'b1;
      ref_cache_addr  = a;
   endtask

   // Per-transfer trace, indexed by cycle after accept (1 = first cycle)
   logic       tr_ale [64], tr_wr [64], tr_rd [64], tr_oe [64];
   logic [7:0] tr_data [64];
   int         g_cycles, g_ale_rises, g_ale_high, g_wr_low, g_rd_low, g_first_wr;
   logic       g_oe_in_rd;
   logic [7:0] g_rdata;

   task automatic wait_ready();
      int guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge osc);
         guard++;
      end
      if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
      logic prev_ale = 1'b0;
      bit   done = 1'b0;
      @(negedge osc);
      chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      wait_ready();
      @(posedge osc);
      @(negedge osc);
      // Scramble the request port: the transfer must use the captured fields
      req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
      g_cycles = 0; g_ale_rises = 0; g_ale_high = 0; g_wr_low = 0; g_rd_low = 0;
      g_first_wr = 0; g_oe_in_rd = 1'b0; g_rdata = 8'h00;
      for (int n = 1; n < 40 && !done; n++) begin
         if (n > 1) @(negedge osc);
         tr_ale[n] = bus_ale; tr_wr[n] = bus_write; tr_rd[n] = bus_read;
         tr_oe[n] = bus_data_oe; tr_data[n] = bus_data_out;
         if (bus_ale && !prev_ale) g_ale_rises++;
         prev_ale = bus_ale;
         g_ale_high += int'(bus_ale);
         if (!bus_write && g_wr_low == 0) g_first_wr = n;
         g_wr_low += int'(!bus_write);
         g_rd_low += int'(!bus_read);
         if (bus_data_oe && !bus_read) g_oe_in_rd = 1'b1;
         if (rsp_valid) begin
            g_cycles = n;
            g_rdata  = rsp_rdata;
            done     = 1'b1;
         end
      end
   endtask

   typedef struct packed {
      logic        w;
      logic [7:0]  a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      logic [31:0] exp_cyc;
      logic [31:0] exp_ale;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic ok;
      int   accepts, rsps, outstanding, bp_viol, guard, nc_ale;
      logic prev;

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      ref_mem[ID_TYPE_LO_ADDR] = 8'h34;
      ref_mem[ID_TYPE_HI_ADDR] = 8'h12;
      ref_mem[ID_SUBTYPE_ADDR] = 8'h01;

      vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 32'd14, 32'd1};
      vecs[1] = '{1'b0, 8'hFF, 8'h00, 8'h01, 32'd14, 32'd1};
      vecs[2] = '{1'b0, 8'hFD, 8'h00, 8'h34, 32'd14, 32'd1};
      vecs[3] = '{1'b0, 8'hFD, 8'h00, 8'h34, 32'd7,  32'd0};
      vecs[4] = '{1'b0, 8'hFE, 8'h00, 8'h12, 32'd14, 32'd1};
      vecs[5] = '{1'b1, 8'h30, 8'h5A, 8'h00, 32'd14, 32'd1};
      vecs[6] = '{1'b1, 8'h30, 8'hC3, 8'h00, 32'd7,  32'd0};
      vecs[7] = '{1'b0, 8'h30, 8'h00, 8'hC3, 32'd7,  32'd0};

      // ---- reset values ----
      repeat (3) @(negedge osc);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_data_out", 32'(bus_data_out), 32'd0);
      chk("rst_oe", 32'(bus_data_oe), 32'd0);
      chk("rst_ale", 32'(bus_ale), 32'd0);
      chk("rst_write", 32'(bus_write), 32'd1);
      chk("rst_read", 32'(bus_read), 32'd1);
      rst = 1'b0;
      #1;
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // ---- directed table ----
      for (int v = 0; v < 8; v++) begin
         run_xfer(vecs[v].w, vecs[v].a, vecs[v].d);
         chk($sformatf("vec%0d_cycles", v), g_cycles, vecs[v].exp_cyc);
         chk($sformatf("vec%0d_ale", v), g_ale_rises, vecs[v].exp_ale);
         if (!vecs[v].w) chk($sformatf("vec%0d_rdata", v), 32'(g_rdata), 32'(vecs[v].exp_rd));
         if (v == 0) begin
            // Write waveform: ALE 3 cycles over the address, WRITE low 3 cycles,
            // data stable 2 cycles either side of the strobe
            chk("wr_ale_high", g_ale_high, TP);
            ok = 1'b1;
            for (int n = 1; n <= 7; n++) if (!tr_oe[n] || tr_data[n] != 8'h12) ok = 1'b0;
            chk("wr_addr_drive", 32'(ok), 32'd1);
            chk("wr_low_cycles", g_wr_low, TP);
            chk("wr_first_low", g_first_wr, 32'd10);
            ok = 1'b1;
            for (int n = g_first_wr - TS; n <= g_first_wr + g_wr_low + TR - 1; n++)
               if (!tr_oe[n] || tr_data[n] != 8'hA5) ok = 1'b0;
            chk("wr_data_window", 32'(ok), 32'd1);
            chk("wr_mem", 32'(slv_mem[8'h12]), 32'hA5);
         end
         if (v == 1) begin
            chk("rd_low_cycles", g_rd_low, TP);
            chk("rd_oe_while_low", 32'(g_oe_in_rd), 32'd0);
         end
         ref_update(vecs[v].w, vecs[v].a, vecs[v].d);
      end

      // ---- reset in the middle of a write strobe ----
      run_xfer(1'b1, 8'h12, 8'h77);
      ref_update(1'b1, 8'h12, 8'h77);
      @(negedge osc);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h12; req_wdata = 8'h88;
      wait_ready();
      @(posedge osc);
      @(negedge osc);
      req_valid = 1'b0;
      guard = 0;
      while (bus_write && guard < 30) begin
         @(negedge osc);
         guard++;
      end
      chk("mid_strobe_reached", 32'(bus_write), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_write", 32'(bus_write), 32'd1);
      chk("midrst_oe", 32'(bus_data_oe), 32'd0);
      chk("midrst_rsp", 32'(rsp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      @(negedge osc);
      rst = 1'b0;
      ref_cache_valid = 1'b0;
      run_xfer(1'b1, 8'h12, 8'h3C);
      chk("post_rst_cycles", g_cycles, FULL_CYC);
      chk("post_rst_ale", g_ale_rises, 32'd1);
      ref_update(1'b1, 8'h12, 8'h3C);

      // ---- backpressure: req_valid held through several transfers ----
      @(negedge osc);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h14; req_wdata = 8'h5E;
      accepts = 0; rsps = 0; outstanding = 0; bp_viol = 0;
      for (int n = 0; n < 200 && rsps < 3; n++) begin
         if (rsp_valid) begin
            if (outstanding != 1) bp_viol++;
            outstanding = 0;
            rsps++;
         end
         if (req_valid && req_ready) begin
            if (outstanding != 0) bp_viol++;
            outstanding = 1;
            accepts++;
         end
         if (rsps == 3) req_valid = 1'b0;
         else @(negedge osc);
      end
      req_valid = 1'b0;
      chk("bp_accepts", accepts, 32'd3);
      chk("bp_rsps", rsps, 32'd3);
      chk("bp_order", bp_viol, 32'd0);
      ref_update(1'b1, 8'h14, 8'h5E);

      // ---- no address cache: two writes to the same address both show ALE ----
      nc_ale = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge osc);
         nc_req_valid = 1'b1;
         guard = 0;
         while (!nc_req_ready && guard < 50) begin
            @(negedge osc);
            guard++;
         end
         @(posedge osc);
         @(negedge osc);
         nc_req_valid = 1'b0;
         prev = 1'b0;
         guard = 1;
         while (!nc_rsp_valid && guard < 40) begin
            if (nc_bus_ale && !prev) nc_ale++;
            prev = nc_bus_ale;
            @(negedge osc);
            guard++;
         end
         chk($sformatf("nc_cycles%0d", k), guard, FULL_CYC);
      end
      chk("nc_ale_pulses", nc_ale, 32'd2);

      // ---- randomized transfers against the reference model ----
      for (int r = 0; r < 40; r++) begin
         int unsigned idx, ecyc, eale;
         logic        w;
         logic [7:0]  a, d;
         idx = $urandom_range(0, 10);
         a   = (idx < 8) ? 8'(8'h10 + idx) : 8'(8'hFD + (idx - 8));
         w   = 1'($urandom_range(0, 1));
         d   = 8'($urandom);
         ecyc = ref_cycles(a);
         eale = ref_ale(a);
         run_xfer(w, a, d);
         chk($sformatf("rnd%0d_cycles a=%0h", r, a), g_cycles, ecyc);
         chk($sformatf("rnd%0d_ale a=%0h", r, a), g_ale_rises, eale);
         chk($sformatf("rnd%0d_addr_ok", r), 32'(a[ADDR_OK_BIT]), 32'd1);
         if (!w) chk($sformatf("rnd%0d_rdata a=%0h", r, a), 32'(g_rdata), 32'(ref_mem[a]));
         ref_update(w, a, d);
      end

      repeat (3) @(negedge osc);
      chk("bus_exclusive", viol, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
